// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core.
// Ports: ID source regs / EX dest and load info in, branch resolve, MEM/IF
//   memory-controller status in; per-register stall/flush controls, PC
//   redirect, stale-fetch discard and two performance counters out.
module pipe_hazard_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs1_read,
    input  logic              id_rs2_read,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_wd,
    input  logic              ex_wreg,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              mem_busy,
    input  logic              if_busy,
    input  logic              if_done,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              id_stall,
    output logic              exmem_stall,
    output logic              branch_interception,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_discard,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic br;
    logic rs1_hit;
    logic rs2_hit;
    logic lu_hit;

    // Hazard terms
    assign freeze  = mem_busy;
    assign br      = ex_branch_taken & ~freeze;
    assign rs1_hit = id_rs1_read & (id_rs1 == ex_wd);
    assign rs2_hit = id_rs2_read & (id_rs2 == ex_wd);
    // x0 is never a real dependency
    assign lu_hit  = ex_is_load & ex_wreg & (ex_wd != '0)
                   & (rs1_hit | rs2_hit);

    // Pipeline controls; priority is reset, freeze, branch, load-use.
    always_comb begin
        pc_stall            = 1'b0;
        ifid_stall          = 1'b0;
        idex_stall          = 1'b0;
        id_stall            = 1'b0;
        exmem_stall         = 1'b0;
        branch_interception = 1'b0;
        pc_redirect         = 1'b0;
        pc_target           = '0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (freeze) begin
            // A branch in EX stays held in ID/EX and fires once unfrozen
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (br) begin
            branch_interception = 1'b1;
            pc_redirect         = 1'b1;
            pc_target           = ex_branch_target;
        end else if (lu_hit) begin
            // One bubble: the load moves to MEM next edge and forwards
            id_stall   = 1'b1;
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
        end
    end

    // Stale-fetch tracking after a redirect
    always_comb begin
        state_d    = state_q;
        if_discard = 1'b0;
        unique case (state_q)
            RUN: begin
                if (br & if_done) begin
                    if_discard = 1'b1;
                end else if (br & if_busy) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only one fetch can be outstanding, so a second
                // branch here just waits for the same return.
                if_discard = if_done;
                if (if_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            if_discard = 1'b0;
        end
    end

    // Performance counters wrap naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(pc_redirect);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver queues hand-computed
// expectations per vector, a monitor compares them at the falling edge.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_rd;
        logic        rs2_rd;
        logic        ld;
        logic [4:0]  wd;
        logic        wreg;
        logic        taken;
        logic [31:0] tgt;
        logic        mbusy;
        logic        ibusy;
        logic        idone;
    } in_t;

    typedef struct {
        int          id;
        logic [7:0]  bits;
        logic [31:0] tgt;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    // bit order: pc ifid idex id exmem bi redir discard
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1101_0000;
    localparam logic [7:0] FRZ  = 8'b1110_1000;
    localparam logic [7:0] BR   = 8'b0000_0110;
    localparam logic [7:0] BRD  = 8'b0000_0111;
    localparam logic [7:0] DISC = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_wd;
    logic        id_rs1_read, id_rs2_read;
    logic        ex_is_load, ex_wreg, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        mem_busy, if_busy, if_done;
    logic        pc_stall, ifid_stall, idex_stall, id_stall;
    logic        exmem_stall, branch_interception, pc_redirect;
    logic [31:0] pc_target;
    logic        if_discard;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t sb[$];
    in_t  cur;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_id   = 0;
    logic [31:0] tot_s = 0;
    logic [31:0] tot_f = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_rs1              (id_rs1),
        .id_rs2              (id_rs2),
        .id_rs1_read         (id_rs1_read),
        .id_rs2_read         (id_rs2_read),
        .ex_is_load          (ex_is_load),
        .ex_wd               (ex_wd),
        .ex_wreg             (ex_wreg),
        .ex_branch_taken     (ex_branch_taken),
        .ex_branch_target    (ex_branch_target),
        .mem_busy            (mem_busy),
        .if_busy             (if_busy),
        .if_done             (if_done),
        .pc_stall            (pc_stall),
        .ifid_stall          (ifid_stall),
        .idex_stall          (idex_stall),
        .id_stall            (id_stall),
        .exmem_stall         (exmem_stall),
        .branch_interception (branch_interception),
        .pc_redirect         (pc_redirect),
        .pc_target           (pc_target),
        .if_discard          (if_discard),
        .stall_cnt           (stall_cnt),
        .flush_cnt           (flush_cnt)
    );

    task automatic drive();
        rst              = cur.rst;
        id_rs1           = cur.rs1;
        id_rs2           = cur.rs2;
        id_rs1_read      = cur.rs1_rd;
        id_rs2_read      = cur.rs2_rd;
        ex_is_load       = cur.ld;
        ex_wd            = cur.wd;
        ex_wreg          = cur.wreg;
        ex_branch_taken  = cur.taken;
        ex_branch_target = cur.tgt;
        mem_busy         = cur.mbusy;
        if_busy          = cur.ibusy;
        if_done          = cur.idone;
    endtask

    // Apply cur between edges and queue what the DUT must show this cycle.
    task automatic step(input logic [7:0] eo, input logic [31:0] et);
        exp_t e;
        @(posedge clk);
        #1;
        drive();
        if (cur.rst) begin
            tot_s = 0;
            tot_f = 0;
        end
        n_id++;
        e.id   = n_id;
        e.bits = eo;
        e.tgt  = et;
        e.sc   = tot_s;
        e.fc   = tot_f;
        sb.push_back(e);
        tot_s = tot_s + 32'(eo[7]);
        tot_f = tot_f + 32'(eo[1]);
    endtask

    task automatic set_lu();
        cur.ld     = 1'b1;
        cur.wreg   = 1'b1;
        cur.wd     = 5'd5;
        cur.rs1_rd = 1'b1;
        cur.rs1    = 5'd5;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = {pc_stall, ifid_stall, idex_stall, id_stall,
                   exmem_stall, branch_interception, pc_redirect,
                   if_discard};
            n_vec++;
            if (got !== e.bits || pc_target !== e.tgt ||
                stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                n_bad++;
                $display("FAIL vec%0d: got ctl=%b tgt=%h sc=%0d fc=%0d, want ctl=%b tgt=%h sc=%0d fc=%0d",
                         e.id, got, pc_target, stall_cnt, flush_cnt,
                         e.bits, e.tgt, e.sc, e.fc);
            end
        end
    end

    initial begin
        cur = '0;
        cur.rst = 1'b1;
        drive();
        step(NONE, 32'h0);
        cur.rst = 1'b0;
        step(NONE, 32'h0);

        // load-use on rs1, then cleared
        set_lu();
        step(LU, 32'h0);
        cur = '0;
        step(NONE, 32'h0);

        // x0 destination never stalls
        cur.ld = 1'b1; cur.wreg = 1'b1; cur.wd = 5'd0;
        cur.rs1_rd = 1'b1; cur.rs1 = 5'd0;
        step(NONE, 32'h0);
        // matching rs2 that is not read
        cur = '0;
        cur.ld = 1'b1; cur.wreg = 1'b1; cur.wd = 5'd7; cur.rs2 = 5'd7;
        step(NONE, 32'h0);
        // same but read: stalls
        cur.rs2_rd = 1'b1;
        step(LU, 32'h0);

        // branch, nothing in flight; RUN after so done is not dropped
        cur = '0;
        cur.taken = 1'b1; cur.tgt = 32'h0000_0104;
        step(BR, 32'h0000_0104);
        cur = '0; cur.idone = 1'b1;
        step(NONE, 32'h0);

        // branch with fetch outstanding, return 3 cycles later
        cur = '0;
        cur.taken = 1'b1; cur.tgt = 32'h0000_0200; cur.ibusy = 1'b1;
        step(BR, 32'h0000_0200);
        cur = '0; cur.ibusy = 1'b1;
        step(NONE, 32'h0);
        step(NONE, 32'h0);
        cur.idone = 1'b1;
        step(DISC, 32'h0);
        step(NONE, 32'h0);

        // branch coinciding with the fetch return in RUN
        cur = '0;
        cur.taken = 1'b1; cur.tgt = 32'h0000_0300;
        cur.ibusy = 1'b1; cur.idone = 1'b1;
        step(BRD, 32'h0000_0300);
        cur = '0; cur.idone = 1'b1;
        step(NONE, 32'h0);

        // second branch while draining keeps DRAIN
        cur = '0;
        cur.taken = 1'b1; cur.tgt = 32'h0000_0400; cur.ibusy = 1'b1;
        step(BR, 32'h0000_0400);
        cur.tgt = 32'h0000_0500;
        step(BR, 32'h0000_0500);
        cur = '0; cur.idone = 1'b1;
        step(DISC, 32'h0);
        step(NONE, 32'h0);

        // clean counters, then freeze over branch + load-use
        cur = '0; cur.rst = 1'b1;
        step(NONE, 32'h0);
        cur.rst = 1'b0;
        set_lu();
        cur.taken = 1'b1; cur.tgt = 32'h0000_0600; cur.mbusy = 1'b1;
        for (int i = 0; i < 4; i++) step(FRZ, 32'h0);
        cur.mbusy = 1'b0;
        step(BR, 32'h0000_0600);

        // enter DRAIN with counters at 4 / 1, then async reset
        cur = '0;
        cur.taken = 1'b1; cur.tgt = 32'h0000_0700; cur.ibusy = 1'b1;
        step(BR, 32'h0000_0700);
        cur = '0; cur.rst = 1'b1; cur.idone = 1'b1;
        set_lu();
        step(NONE, 32'h0);
        cur = '0; cur.idone = 1'b1;
        step(NONE, 32'h0);
        cur = '0;
        step(NONE, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0",
                     sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Produces the control inputs consumed by the pipeline registers: `pc_stall`, `ifid_stall`, `idex_stall`, `id_stall`, `exmem_stall`, `branch_interception`.
- Also drives the PC redirect, and discards a stale in-flight instruction fetch after a taken branch.
- Keeps two performance counters.

Parameters:
- ADDR_W, 32, PC / branch-target width.
- REG_W, 5, register-address width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- id_rs1  in  REG_W  rs1 address of the instruction in ID.
- id_rs2  in  REG_W  rs2 address of the instruction in ID.
- id_rs1_read  in  1  ID instruction reads rs1.
- id_rs2_read  in  1  ID instruction reads rs2.
- ex_is_load  in  1  instruction in EX is a load.
- ex_wd  in  REG_W  EX destination register.
- ex_wreg  in  1  EX writes a register.
- ex_branch_taken  in  1  EX resolved a taken branch/jump (mispredict).
- ex_branch_target  in  ADDR_W  correct next PC.
- mem_busy  in  1  MEM stage waiting on memory controller.
- if_busy  in  1  instruction fetch outstanding at memory controller.
- if_done  in  1  one-cycle pulse: fetch data returned.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- idex_stall  out  1  hold ID/EX.
- id_stall  out  1  load bubble into ID/EX (ID/EX clears).
- exmem_stall  out  1  hold EX/MEM.
- branch_interception  out  1  flush IF/ID and ID/EX.
- pc_redirect  out  1  load PC from pc_target.
- pc_target  out  ADDR_W  redirect address.
- if_discard  out  1  drop the returning fetch (IF must not write IF/ID).
- stall_cnt  out  CNT_W  cycles with pc_stall=1.
- flush_cnt  out  CNT_W  taken redirects.

Behaviour:

Combinational terms:
- `freeze = mem_busy`.
- `lu_hit = ex_is_load & ex_wreg & (ex_wd!=0) & ((id_rs1_read & id_rs1==ex_wd) | (id_rs2_read & id_rs2==ex_wd))`.
- `br = ex_branch_taken & !freeze`.

Priority: rst > freeze > br > lu_hit.

Outputs per cycle, all combinational from inputs plus state:
- **freeze**: `pc_stall = ifid_stall = idex_stall = exmem_stall = 1`; `id_stall = 0`; `branch_interception = 0`; `pc_redirect = 0`. A branch in EX is held by the frozen ID/EX and acts on the first unfrozen cycle.
- **br**: `branch_interception = 1`, `pc_redirect = 1`, `pc_target = ex_branch_target`; all stalls 0; `id_stall = 0` (flush overrides load bubble).
- **lu_hit, no freeze, no br**:
  - `id_stall = 1`, `pc_stall = 1`, `ifid_stall = 1`; `idex_stall = 0`, `exmem_stall = 0`.
  - Exactly one bubble, because the load leaves EX at the next edge and MEM forwarding covers it.
- **Otherwise**: all 0.
- `pc_target` is 0 whenever `pc_redirect = 0`.

State machine (registered): RUN, DRAIN.
- **RUN → DRAIN**: `br & if_busy & !if_done` (stale fetch in flight).
- **RUN, br & if_done same cycle**: `if_discard = 1` that cycle; stay RUN.
- **DRAIN**:
  - `if_discard = if_done`.
  - `if_done` → RUN.
  - A second br while in DRAIN stays DRAIN; at most one fetch is outstanding.
  - `pc_stall` is unaffected by DRAIN; IF issues the new fetch after the discard.
- **RUN, !br**: `if_discard = 0`.

Counters (registered):
- `stall_cnt` increments when `pc_stall = 1`.
- `flush_cnt` increments when `pc_redirect = 1`.
- Both wrap modulo 2^CNT_W.

Reset:
- Asynchronous `rst` forces state RUN and both counters to 0 immediately.
- While `rst = 1`, every output is 0.
- Reset mid-DRAIN abandons the discard; the memory controller is reset by the same `rst`.

Test Plan:
- **Load-use**: ex_is_load=1, ex_wreg=1, ex_wd=5, id_rs1_read=1, id_rs1=5 for one cycle.
  - That cycle: id_stall=1, pc_stall=1, ifid_stall=1, idex_stall=0.
  - Next cycle (ex_is_load=0): all 0. stall_cnt=1.
- **x0 and unused source**: ex_wd=0 with id_rs1=0 read gives id_stall=0. ex_wd=7 matching id_rs2=7 with id_rs2_read=0 also gives id_stall=0.
- **Branch, no fetch pending**: ex_branch_taken=1, ex_branch_target=0x00000104, if_busy=0.
  - branch_interception=1, pc_redirect=1, pc_target=0x104.
  - Next cycle state stays RUN; flush_cnt=1.
- **Branch with fetch in flight**: br with if_busy=1, if_done=0.
  - State goes DRAIN.
  - if_done pulse 3 cycles later gives if_discard=1 that cycle, then RUN.
  - A subsequent if_done gives if_discard=0.
- **Freeze over branch and load-use**:
  - mem_busy=1 for 4 cycles while ex_branch_taken=1 and lu_hit=1: all four holds=1, branch_interception=0, id_stall=0.
  - Cycle after mem_busy falls: branch_interception=1, pc_redirect=1.
  - stall_cnt=4.
- **Async reset**: assert rst between edges while in DRAIN with counters nonzero.
  - Outputs and counters read 0 before the next clk edge.
  - After release: state RUN, first if_done gives if_discard=0.
